// File: rtl/ifetch32_pkg.sv
// Shared types and constants for the ifetch32 instruction fetch sequencer.
// The fetch FSM encoding lives here so the bench and other blocks can share it.
package ifetch32_pkg;

    localparam int FULLW = 32;

    localparam logic [FULLW-1:0] NOP_INSTR   = '0;
    localparam logic [FULLW-1:0] LINK_OFFSET = 32'd4;
    localparam logic [FULLW-1:0] BRANCH_BIAS = 32'd8;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } fetch_state_t;

    // Branch offsets are relative to the branch address plus 8 (pipeline lookahead).
    function automatic logic [FULLW-1:0] branch_target(input logic [FULLW-1:0] pc,
                                                       input logic [FULLW-1:0] offset);
        return pc + BRANCH_BIAS + offset;
    endfunction

endpackage

// File: rtl/ifetch32.sv
// Instruction fetch / PC sequencer: single-outstanding fetch to instruction memory,
// feeds the decode slot, redirects on taken branches and produces the r14 link value.
module ifetch32
    import ifetch32_pkg::*;
#(
    parameter logic [FULLW-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned      PC_STEP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [FULLW-1:0] imem_addr,
    input  logic [FULLW-1:0] imem_rdata,
    input  logic             imem_valid,
    input  logic             stall,
    input  logic             ib_in,
    input  logic             bl_in,
    input  logic [FULLW-1:0] bv_in,
    output logic [FULLW-1:0] iout,
    output logic             ispb_out,
    output logic [FULLW-1:0] dec_pc,
    output logic [FULLW-1:0] link_out,
    output logic             link_we
);

    localparam logic [FULLW-1:0] STEP = FULLW'(PC_STEP);

    fetch_state_t     state_q, state_d;
    logic             active_q;
    logic [FULLW-1:0] fetch_pc_q, fetch_pc_d;
    logic [FULLW-1:0] drop_addr_q, drop_addr_d;
    logic [FULLW-1:0] hold_buf_q, hold_buf_d;
    logic [FULLW-1:0] iout_q, iout_d;
    logic [FULLW-1:0] dec_pc_q, dec_pc_d;
    logic             ispb_q, ispb_d;
    logic [FULLW-1:0] link_q, link_d;
    logic             link_we_q, link_we_d;
    logic             fire;
    logic             take;
    logic             deliver;

    // active_q keeps req low for the first cycle after reset release.
    assign imem_req  = active_q && (state_q != S_HOLD);
    assign imem_addr = (state_q == S_DROP) ? drop_addr_q : fetch_pc_q;
    assign fire      = imem_req && imem_valid;
    assign take      = ib_in && !stall && (state_q != S_DROP);

    assign iout     = iout_q;
    assign ispb_out = ispb_q;
    assign dec_pc   = dec_pc_q;
    assign link_out = link_q;
    assign link_we  = link_we_q;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        drop_addr_d = drop_addr_q;
        hold_buf_d  = hold_buf_q;
        iout_d      = iout_q;
        dec_pc_d    = dec_pc_q;
        ispb_d      = ispb_q;
        link_d      = link_q;
        link_we_d   = 1'b0;
        deliver     = 1'b0;

        if (take) begin
            fetch_pc_d = branch_target(dec_pc_q, bv_in);
            iout_d     = NOP_INSTR;
            ispb_d     = 1'b1;
            if (bl_in) begin
                link_d    = dec_pc_q + LINK_OFFSET;
                link_we_d = 1'b1;
            end
            // A still-pending wrong-path fetch must complete before the target is requested.
            if ((state_q == S_FETCH) && imem_req && !imem_valid) begin
                state_d     = S_DROP;
                drop_addr_d = fetch_pc_q;
            end else begin
                state_d = S_FETCH;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (fire && !stall) begin
                        deliver = 1'b1;
                    end else if (fire) begin
                        hold_buf_d = imem_rdata;
                        state_d    = S_HOLD;
                    end else if (!stall) begin
                        iout_d = NOP_INSTR;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        deliver = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_DROP: begin
                    if (fire) begin
                        state_d = S_FETCH;
                    end
                    if (!stall) begin
                        iout_d = NOP_INSTR;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end

        if (deliver) begin
            iout_d     = (state_q == S_HOLD) ? hold_buf_q : imem_rdata;
            dec_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + STEP;
            ispb_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            active_q    <= 1'b0;
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= RESET_PC;
            hold_buf_q  <= NOP_INSTR;
            iout_q      <= NOP_INSTR;
            dec_pc_q    <= '0;
            ispb_q      <= 1'b0;
            link_q      <= '0;
            link_we_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_q    <= 1'b1;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
            hold_buf_q  <= hold_buf_d;
            iout_q      <= iout_d;
            dec_pc_q    <= dec_pc_d;
            ispb_q      <= ispb_d;
            link_q      <= link_d;
            link_we_q   <= link_we_d;
        end
    end

endmodule

// File: tb/tb_ifetch32.sv
// Randomized scoreboard bench for ifetch32: a program-flow model predicts the
// address/word stream and link values; a negedge monitor checks them as they appear.
module tb_ifetch32;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        stall;
    logic        ib_in;
    logic        bl_in;
    logic [31:0] bv_in;
    logic [31:0] iout;
    logic        ispb_out;
    logic [31:0] dec_pc;
    logic [31:0] link_out;
    logic        link_we;

    int check_count = 0;
    int pass_count  = 0;

    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_link_q[$];

    bit          force_stall = 1'b0;
    logic [31:0] model_pc;
    logic [31:0] model_next_pc;
    bit          need_new;
    bit          cur_br;
    bit          cur_bl;
    logic [31:0] cur_bv;

    ifetch32 #(.RESET_PC(RESET_PC), .PC_STEP(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .stall      (stall),
        .ib_in      (ib_in),
        .bl_in      (bl_in),
        .bv_in      (bv_in),
        .iout       (iout),
        .ispb_out   (ispb_out),
        .dec_pc     (dec_pc),
        .link_out   (link_out),
        .link_we    (link_we)
    );

    always #5 clk = ~clk;

    // Every address holds a distinct, never-zero instruction word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b01} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] pick_offset();
        logic [31:0] tmp;
        case ($urandom_range(0, 3))
            0: tmp = 32'h0000_0020;
            1: tmp = 32'hFFFF_FFF8;
            2: tmp = ($urandom_range(0, 32) * 4) - 64;
            default: begin
                tmp = $urandom();
                tmp[1:0] = 2'b00;
            end
        endcase
        return tmp;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    task automatic resetModel();
        exp_pc_q.delete();
        exp_link_q.delete();
        model_pc      = RESET_PC;
        model_next_pc = RESET_PC;
        exp_pc_q.push_back(RESET_PC);
        need_new = 1'b1;
        cur_br   = 1'b0;
        cur_bl   = 1'b0;
        cur_bv   = '0;
    endtask

    task automatic checkResetValues();
        checkOutput("rst_iout", iout, 32'h0);
        checkOutput("rst_ispb", {31'b0, ispb_out}, 32'h0);
        checkOutput("rst_dec_pc", dec_pc, 32'h0);
        checkOutput("rst_link_out", link_out, 32'h0);
        checkOutput("rst_link_we", {31'b0, link_we}, 32'h0);
        checkOutput("rst_req", {31'b0, imem_req}, 32'h0);
        checkOutput("rst_addr", imem_addr, RESET_PC);
    endtask

    // Decoder stand-in: picks branch behaviour per instruction and predicts the next fetch.
    task automatic applyStimulus();
        bit real_instr;
        real_instr = (iout != 32'h0);
        if (real_instr && need_new) begin
            model_pc = model_next_pc;
            need_new = 1'b0;
            cur_br   = ($urandom_range(0, 3) == 0);
            cur_bl   = cur_br && ($urandom_range(0, 1) == 1);
            cur_bv   = pick_offset();
        end
        stall = force_stall || ($urandom_range(0, 3) == 0);
        ib_in = real_instr && cur_br;
        bl_in = real_instr && cur_bl;
        bv_in = cur_bv;
        if (real_instr && !stall) begin
            model_next_pc = cur_br ? (model_pc + 32'd8 + cur_bv) : (model_pc + 32'd4);
            exp_pc_q.push_back(model_next_pc);
            if (cur_br && cur_bl) exp_link_q.push_back(model_pc + 32'd4);
            need_new = 1'b1;
        end
    endtask

    task automatic releaseReset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 checkOutput("req_low_at_release", {31'b0, imem_req}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("first_req", {31'b0, imem_req}, 32'h1);
        checkOutput("first_addr", imem_addr, RESET_PC);
        applyStimulus();
    endtask

    // Instruction memory: random 0..2 cycle latency, occasional stray valid while idle.
    initial begin
        int lat;
        lat = -1;
        imem_valid = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                imem_valid = 1'b0;
                lat = -1;
            end else if (!imem_req) begin
                lat = -1;
                imem_valid = ($urandom_range(0, 3) == 0);
                imem_rdata = 32'hDEAD_BEEF;
            end else begin
                if (lat < 0) lat = $urandom_range(0, 2);
                if (lat == 0) begin
                    imem_valid = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    lat = -1;
                end else begin
                    imem_valid = 1'b0;
                    imem_rdata = 32'h0BAD_0BAD;
                    lat--;
                end
            end
        end
    end

    // Monitor: detects new deliveries into the decode slot and checks them against the scoreboard.
    initial begin
        bit          p_have, p_stall, p_branch, p_bl, p_req, p_valid, deliver;
        logic [31:0] p_iout, p_addr, e;
        int          idle;
        p_have = 1'b0;
        idle   = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_have = 1'b0;
                idle   = 0;
            end else begin
                deliver = (iout != 32'h0) && (!p_have || (p_iout == 32'h0) || !p_stall);
                if (deliver) begin
                    idle = 0;
                    if (exp_pc_q.size() == 0) begin
                        check_count++;
                        $display("[TB] FAIL unexpected_delivery: got iout 0x%08h at 0x%08h, expected none", iout, dec_pc);
                    end else begin
                        e = exp_pc_q.pop_front();
                        checkOutput("deliver_dec_pc", dec_pc, e);
                        checkOutput("deliver_word", iout, mem_word(e));
                        checkOutput("deliver_ispb_clear", {31'b0, ispb_out}, 32'h0);
                    end
                end else if (p_have && !p_stall) begin
                    idle++;
                    if (idle > 40) begin
                        checkOutput("delivery_timeout", idle, 32'h0);
                        idle = 0;
                    end
                end
                if (p_have && p_branch) begin
                    checkOutput("branch_bubble", iout, 32'h0);
                    checkOutput("branch_ispb", {31'b0, ispb_out}, 32'h1);
                end
                if (p_have) checkOutput("link_we", {31'b0, link_we}, {31'b0, p_branch && p_bl});
                if (link_we && exp_link_q.size() != 0) begin
                    e = exp_link_q.pop_front();
                    checkOutput("link_out", link_out, e);
                end
                if (p_have && p_req && !p_valid && imem_req) checkOutput("addr_stable", imem_addr, p_addr);
                p_have   = 1'b1;
                p_iout   = iout;
                p_stall  = stall;
                p_branch = (iout != 32'h0) && ib_in && !stall;
                p_bl     = bl_in;
                p_req    = imem_req;
                p_valid  = imem_valid;
                p_addr   = imem_addr;
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        stall = 1'b0;
        ib_in = 1'b0;
        bl_in = 1'b0;
        bv_in = 32'h0;
        resetModel();
        #12;
        checkResetValues();
        releaseReset();
        repeat (1500) begin
            @(posedge clk);
            #1 applyStimulus();
        end

        // Hold the decode slot until the fetcher parks a word, then reset mid-hold.
        force_stall = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1 applyStimulus();
            n++;
        end while (imem_req && n < 30);
        checkOutput("hold_req_low", {31'b0, imem_req}, 32'h0);
        repeat (3) begin
            @(posedge clk);
            #1 applyStimulus();
        end
        checkOutput("hold_iout_frozen", iout, need_new ? 32'h0 : mem_word(model_pc));
        if (!need_new) checkOutput("hold_dec_pc", dec_pc, model_pc);
        checkOutput("hold_req_still_low", {31'b0, imem_req}, 32'h0);
        #2 rst_n = 1'b0;
        #1 checkResetValues();
        resetModel();
        force_stall = 1'b0;
        releaseReset();
        repeat (1000) begin
            @(posedge clk);
            #1 applyStimulus();
        end

        @(posedge clk);
        #1;
        stall = 1'b1;
        ib_in = 1'b0;
        bl_in = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("link_queue_drained", exp_link_q.size(), 32'h0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
